// File: rtl/tcdm_error_responder.sv
// TCDM error-port terminator: grants every request, answers one cycle later with an error
// response, captures the first faulting access, counts faults and pulses an interrupt.
// Optional fault address log enabled by defining TCDM_ERROR_RESPONDER_LOG_EN.
module tcdm_error_responder #(
  parameter logic [31:0] ERR_RDATA = 32'hBADA_CCE5,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [31:0]          add_i,
  input  logic                 wen_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic                 gnt_o,
  output logic                 r_valid_o,
  output logic [31:0]          r_rdata_o,
  output logic                 r_opc_o,
  input  logic                 clear_i,
  output logic                 err_valid_o,
  output logic [31:0]          err_addr_o,
  output logic                 err_wen_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 irq_o,
  input  logic                 log_pop_i,
  output logic                 log_empty_o,
  output logic [31:0]          log_addr_o,
  output logic                 log_overflow_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic                 r_rsp_valid;
  logic                 r_rsp_wen;
  logic                 r_err_valid;
  logic [31:0]          r_err_addr;
  logic                 r_err_wen;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic                 r_irq;
  logic                 w_cap_armed;

  // No backpressure: every request is accepted in the cycle it is presented.
  assign gnt_o = req_i;

  // Response pipeline: one stage, remembers whether the accepted access was a read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_wen   <= 1'b0;
    end else begin
      r_rsp_valid <= req_i;
      r_rsp_wen   <= wen_i;
    end
  end

  assign r_valid_o = r_rsp_valid;
  assign r_opc_o   = r_rsp_valid;
  assign r_rdata_o = (r_rsp_valid && r_rsp_wen) ? ERR_RDATA : 32'h0;

  // A clear in the same cycle re-arms capture before the accept is considered.
  assign w_cap_armed = clear_i | ~r_err_valid;

  // First-fault capture, saturating counter and interrupt pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= 32'h0;
      r_err_wen   <= 1'b0;
      r_err_cnt   <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= req_i & w_cap_armed;
      if (req_i && w_cap_armed) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= add_i;
        r_err_wen   <= wen_i;
      end else if (clear_i) begin
        r_err_valid <= 1'b0;
        r_err_addr  <= 32'h0;
        r_err_wen   <= 1'b0;
      end
      if (clear_i) begin
        r_err_cnt <= req_i ? CNT_WIDTH'(1) : '0;
      end else if (req_i && (r_err_cnt != CntMax)) begin
        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_wen_o   = r_err_wen;
  assign err_cnt_o   = r_err_cnt;
  assign irq_o       = r_irq;

`ifdef TCDM_ERROR_RESPONDER_LOG_EN
  localparam int unsigned PtrW = $clog2(LOG_DEPTH);
  localparam logic [PtrW:0] LogFull = (PtrW+1)'(LOG_DEPTH);

  logic [31:0]     r_log_mem [LOG_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_log_cnt;
  logic            r_log_ovf;
  logic            w_log_full;
  logic            w_log_empty;
  logic            w_pop;
  logic            w_push;
  logic [PtrW-1:0] w_wr_idx;
  logic            w_unused;

  assign w_log_full  = (r_log_cnt == LogFull);
  assign w_log_empty = (r_log_cnt == '0);
  // Clear empties the log first, so a pop alongside it has nothing to remove.
  assign w_pop       = log_pop_i & ~w_log_empty & ~clear_i;
  assign w_push      = req_i & (clear_i | ~w_log_full | w_pop);
  assign w_wr_idx    = clear_i ? '0 : r_wr_ptr;

  // Log pointers, occupancy and overflow flag; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_log_cnt <= '0;
      r_log_ovf <= 1'b0;
    end else if (clear_i) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= w_push ? PtrW'(1) : '0;
      r_log_cnt <= w_push ? (PtrW+1)'(1) : '0;
      r_log_ovf <= 1'b0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_log_cnt <= r_log_cnt + (PtrW+1)'(1);
        2'b01:   r_log_cnt <= r_log_cnt - (PtrW+1)'(1);
        default: r_log_cnt <= r_log_cnt;
      endcase
      if (req_i && !w_push) r_log_ovf <= 1'b1;
    end
  end

  // Log storage; contents are only observed through the valid window, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_log_mem[w_wr_idx] <= add_i;
  end

  assign log_empty_o    = w_log_empty;
  assign log_addr_o     = w_log_empty ? 32'h0 : r_log_mem[r_rd_ptr];
  assign log_overflow_o = r_log_ovf;
  assign w_unused       = ^{wdata_i, be_i};
`else
  logic w_unused;

  assign log_empty_o    = 1'b1;
  assign log_addr_o     = 32'h0;
  assign log_overflow_o = 1'b0;
  assign w_unused       = ^{wdata_i, be_i, log_pop_i};
`endif

endmodule

// File: tb/tb_tcdm_error_responder.sv
// Randomized and directed bench for tcdm_error_responder against a transaction-level model.
module tb_tcdm_error_responder;

  localparam logic [31:0] ERR   = 32'hBADA_CCE5;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, wen, clear, pop;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt, r_valid, r_opc, err_valid, err_wen, irq, log_empty, log_ovf;
  logic [31:0] r_rdata, err_addr, log_addr;
  logic [15:0] err_cnt;

  logic        sm_gnt, sm_r_valid, sm_r_opc, sm_err_valid, sm_err_wen, sm_irq;
  logic        sm_log_empty, sm_log_ovf;
  logic [31:0] sm_r_rdata, sm_err_addr, sm_log_addr;
  logic [1:0]  sm_err_cnt;

  tcdm_error_responder #(.ERR_RDATA(ERR), .CNT_WIDTH(16), .LOG_DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
    .clear_i(clear), .err_valid_o(err_valid), .err_addr_o(err_addr), .err_wen_o(err_wen),
    .err_cnt_o(err_cnt), .irq_o(irq), .log_pop_i(pop), .log_empty_o(log_empty),
    .log_addr_o(log_addr), .log_overflow_o(log_ovf)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  tcdm_error_responder #(.ERR_RDATA(ERR), .CNT_WIDTH(2), .LOG_DEPTH(DEPTH)) u_dut_sm (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .gnt_o(sm_gnt), .r_valid_o(sm_r_valid), .r_rdata_o(sm_r_rdata),
    .r_opc_o(sm_r_opc), .clear_i(clear), .err_valid_o(sm_err_valid),
    .err_addr_o(sm_err_addr), .err_wen_o(sm_err_wen), .err_cnt_o(sm_err_cnt), .irq_o(sm_irq),
    .log_pop_i(pop), .log_empty_o(sm_log_empty), .log_addr_o(sm_log_addr),
    .log_overflow_o(sm_log_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_rsp_v, m_rsp_wen, m_cap_v, m_cap_wen, m_irq, m_ovf;
  logic [31:0] m_cap_addr;
  int unsigned m_cnt, m_cnt2;
  logic [31:0] m_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rsp_v = 0; m_rsp_wen = 0; m_cap_v = 0; m_cap_wen = 0; m_irq = 0; m_ovf = 0;
    m_cap_addr = 32'h0; m_cnt = 0; m_cnt2 = 0;
    m_log.delete();
  endtask

  // One clock of the specified behaviour, using the inputs seen at this edge.
  task automatic model_update();
    m_rsp_v   = req;
    m_rsp_wen = wen;
    m_irq     = 0;
    if (clear) begin
      m_cap_v = 0; m_cap_addr = 32'h0; m_cap_wen = 0; m_cnt = 0; m_cnt2 = 0;
      m_log.delete(); m_ovf = 0;
    end
`ifdef TCDM_ERROR_RESPONDER_LOG_EN
    if (pop && m_log.size() > 0) void'(m_log.pop_front());
    if (req) begin
      if (m_log.size() < DEPTH) m_log.push_back(add);
      else m_ovf = 1;
    end
`endif
    if (req) begin
      if (!m_cap_v) begin
        m_cap_v = 1; m_cap_addr = add; m_cap_wen = wen; m_irq = 1;
      end
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check_outputs();
    chk("r_valid", 32'(r_valid), 32'(m_rsp_v));
    chk("r_opc", 32'(r_opc), 32'(m_rsp_v));
    chk("r_rdata", r_rdata, m_rsp_v ? (m_rsp_wen ? ERR : 32'h0) : 32'h0);
    chk("err_valid", 32'(err_valid), 32'(m_cap_v));
    if (m_cap_v) begin
      chk("err_addr", err_addr, m_cap_addr);
      chk("err_wen", 32'(err_wen), 32'(m_cap_wen));
    end
    chk("err_cnt", 32'(err_cnt), m_cnt);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("sm_err_cnt", 32'(sm_err_cnt), m_cnt2);
    chk("sm_irq", 32'(sm_irq), 32'(m_irq));
    chk("sm_r_valid", 32'(sm_r_valid), 32'(m_rsp_v));
`ifdef TCDM_ERROR_RESPONDER_LOG_EN
    chk("log_empty", 32'(log_empty), 32'(m_log.size() == 0));
    chk("log_addr", log_addr, (m_log.size() > 0) ? m_log[0] : 32'h0);
    chk("log_ovf", 32'(log_ovf), 32'(m_ovf));
`else
    chk("log_empty", 32'(log_empty), 32'h1);
    chk("log_addr", log_addr, 32'h0);
    chk("log_ovf", 32'(log_ovf), 32'h0);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(req));
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic cyc(input bit r, input logic [31:0] a, input bit w, input bit c, input bit p);
    req = r; add = a; wen = w; clear = c; pop = p;
    wdata = $urandom; be = 4'($urandom);
    step();
  endtask

  task automatic do_reset();
    req = 0; add = 0; wen = 0; clear = 0; pop = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 check_outputs();
  endtask

  int irqs;
  logic [1:0] sm_exp [5];

  initial begin
    rst = 1; req = 0; add = 0; wen = 0; clear = 0; pop = 0; wdata = 0; be = 0;
    model_reset();
    do_reset();

    // First read fault
    cyc(1, 32'h1A10_0000, 1, 0, 0);
    chk("t1_rdata", r_rdata, 32'hBADACCE5);
    chk("t1_addr", err_addr, 32'h1A10_0000);
    cyc(0, 0, 0, 0, 0);

    // Write then three back-to-back reads
    do_reset();
    irqs = 0;
    cyc(1, 32'h4, 0, 0, 0); irqs += int'(irq);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h100 + 32'(i), 1, 0, 0); irqs += int'(irq);
    end
    cyc(0, 0, 0, 0, 0); irqs += int'(irq);
    chk("t2_addr", err_addr, 32'h4);
    chk("t2_cnt", 32'(err_cnt), 32'd4);
    chk("t2_irqs", 32'(irqs), 32'd1);

    // Narrow counter saturation
    do_reset();
    sm_exp[0] = 2'd1; sm_exp[1] = 2'd2; sm_exp[2] = 2'd3; sm_exp[3] = 2'd3; sm_exp[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h800 + 32'(i), 1, 0, 0);
      chk("t3_sm_cnt", 32'(sm_err_cnt), 32'(sm_exp[i]));
    end

    // Clear together with an accept
    cyc(1, 32'h2000, 1, 1, 0);
    chk("t4_cnt", 32'(err_cnt), 32'd1);
    chk("t4_addr", err_addr, 32'h2000);
    chk("t4_irq", 32'(irq), 32'd1);
    cyc(0, 0, 0, 0, 0);

`ifdef TCDM_ERROR_RESPONDER_LOG_EN
    // Log overflow then drain
    cyc(0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 32'(i * 16), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_ovf", 32'(log_ovf), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_head", log_addr, 32'(i * 16));
      cyc(0, 0, 0, 0, 1);
    end
    chk("t5_empty", 32'(log_empty), 32'd1);
    // Full with simultaneous push and pop: no overflow
    cyc(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 1, 0, 0);
    cyc(1, 32'h99, 1, 0, 1);
    chk("t5_pp_ovf", 32'(log_ovf), 32'd0);
    // Pop on empty with push
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h77, 1, 0, 1);
    chk("t5_ep_head", log_addr, 32'h77);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 6), $urandom, 1'($urandom),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 4));
    end

    // Reset asserted while a response is on the bus
    cyc(1, 32'h3000, 1, 0, 0);
    rst = 1;
    req = 0;
    #1;
    chk("t6_rvalid_in_rst", 32'(r_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    chk("t6_rvalid_held", 32'(r_valid), 32'd0);
    #1 rst = 0;
    #1 check_outputs();
    chk("t6_log_empty", 32'(log_empty), 32'd1);
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
